// File: rtl/dota_pkg.sv
// rtl/dota_pkg.sv - shared types and constants for the OTA offset-calibration sequencer
package dota_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DECIDE,
    ST_DONE
  } cal_state_t;

  localparam int TRIM_W_DEF = 6;
  localparam logic [TRIM_W_DEF-1:0] TRIM_MID_DEF = 6'h20;

endpackage

// File: rtl/dota_sync2.sv
// rtl/dota_sync2.sv - two-flop synchroniser for the asynchronous comparator output
module dota_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/dota_offset_cal_ctrl.sv
// rtl/dota_offset_cal_ctrl.sv - SAR offset-trim sequencer with majority-voted comparator decisions
module dota_offset_cal_ctrl
  import dota_pkg::*;
#(
  parameter int TRIM_W     = TRIM_W_DEF,
  parameter int SETTLE_CYC = 16,
  parameter int AVG_LOG2   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              cmp_in,
  input  logic              trim_ovr_en,
  input  logic [TRIM_W-1:0] trim_ovr_val,
  output logic              cal_short,
  output logic [TRIM_W-1:0] trim_code,
  output logic              busy,
  output logic              done,
  output logic              fail
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int IDX_W = $clog2(TRIM_W);
  localparam logic [TRIM_W-1:0] MID         = {1'b1, {(TRIM_W-1){1'b0}}};
  localparam logic [TRIM_W-1:0] ALL_ONES    = '1;
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0]  HALF        = CNT_W'(1 << (AVG_LOG2 - 1));
  localparam logic [IDX_W-1:0]  IDX_MSB     = IDX_W'(TRIM_W - 1);

  cal_state_t        state_q, state_d;
  logic [SET_W-1:0]  set_cnt_q, set_cnt_d;
  logic [CNT_W-1:0]  smp_cnt_q, smp_cnt_d;
  logic [CNT_W-1:0]  ones_q, ones_d;
  logic [TRIM_W-1:0] work_code_q, work_code_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [IDX_W-1:0]  bit_idx_m1;
  logic [TRIM_W-1:0] result_code_q, result_code_d;
  logic [TRIM_W-1:0] trim_code_q, trim_code_d;
  logic              cal_short_q, cal_short_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic              cmp_s;

  dota_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (cmp_in),
    .q_out (cmp_s)
  );

  assign bit_idx_m1 = bit_idx_q - IDX_W'(1);

  always_comb begin
    state_d       = state_q;
    set_cnt_d     = set_cnt_q;
    smp_cnt_d     = smp_cnt_q;
    ones_d        = ones_q;
    work_code_d   = work_code_q;
    bit_idx_d     = bit_idx_q;
    result_code_d = result_code_q;
    cal_short_d   = cal_short_q;
    busy_d        = busy_q;
    done_d        = done_q;
    fail_d        = fail_q;

    case (state_q)
      ST_IDLE: begin
        if (start && ena) begin
          state_d     = ST_SETTLE;
          work_code_d = MID;
          bit_idx_d   = IDX_MSB;
          set_cnt_d   = '0;
          busy_d      = 1'b1;
          cal_short_d = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
        end
      end
      ST_SETTLE: begin
        smp_cnt_d = '0;
        ones_d    = '0;
        if (set_cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
        else                          set_cnt_d = set_cnt_q + SET_W'(1);
      end
      ST_SAMPLE: begin
        ones_d = ones_q + CNT_W'(cmp_s);
        if (smp_cnt_q == SAMPLE_LAST) state_d = ST_DECIDE;
        else                          smp_cnt_d = smp_cnt_q + CNT_W'(1);
      end
      ST_DECIDE: begin
        // Comparator high on a strict majority means the trim is too large; a tie keeps the bit.
        if (ones_q > HALF) work_code_d[bit_idx_q] = 1'b0;
        if (bit_idx_q != '0) begin
          work_code_d[bit_idx_m1] = 1'b1;
          bit_idx_d = bit_idx_m1;
          set_cnt_d = '0;
          state_d   = ST_SETTLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result_code_d = work_code_q;
        busy_d        = 1'b0;
        cal_short_d   = 1'b0;
        done_d        = 1'b1;
        fail_d        = (work_code_q == '0) || (work_code_q == ALL_ONES);
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!ena && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      result_code_d = result_code_q;
      busy_d        = 1'b0;
      cal_short_d   = 1'b0;
      done_d        = 1'b0;
      fail_d        = 1'b0;
    end

    if (trim_ovr_en) trim_code_d = trim_ovr_val;
    else if (busy_q) trim_code_d = work_code_q;
    else             trim_code_d = result_code_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      set_cnt_q     <= '0;
      smp_cnt_q     <= '0;
      ones_q        <= '0;
      work_code_q   <= MID;
      bit_idx_q     <= IDX_MSB;
      result_code_q <= MID;
      trim_code_q   <= MID;
      cal_short_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      set_cnt_q     <= set_cnt_d;
      smp_cnt_q     <= smp_cnt_d;
      ones_q        <= ones_d;
      work_code_q   <= work_code_d;
      bit_idx_q     <= bit_idx_d;
      result_code_q <= result_code_d;
      trim_code_q   <= trim_code_d;
      cal_short_q   <= cal_short_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
    end
  end

  assign cal_short = cal_short_q;
  assign trim_code = trim_code_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_dota_offset_cal_ctrl.sv
// tb/tb_dota_offset_cal_ctrl.sv - directed bench for the OTA offset-calibration sequencer
module tb_dota_offset_cal_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       cmp_in = 1'b0;
  logic       trim_ovr_en;
  logic [5:0] trim_ovr_val;
  logic       cal_short;
  logic [5:0] trim_code;
  logic       busy;
  logic       done;
  logic       fail;

  logic ota_mode = 1'b0;
  logic alt_mode = 1'b0;
  logic cmp_val  = 1'b0;

  int total = 0;
  int bad   = 0;
  int lat;

  dota_offset_cal_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .start        (start),
    .cmp_in       (cmp_in),
    .trim_ovr_en  (trim_ovr_en),
    .trim_ovr_val (trim_ovr_val),
    .cal_short    (cal_short),
    .trim_code    (trim_code),
    .busy         (busy),
    .done         (done),
    .fail         (fail)
  );

  always #5 clk = ~clk;

  // Comparator source: OTA model with offset threshold 0x17, alternating pattern, or constant.
  always @(negedge clk) begin
    if (ota_mode)      cmp_in = (trim_code > 6'h17);
    else if (alt_mode) cmp_in = ~cmp_in;
    else               cmp_in = cmp_val;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cal(input int mode, output int latency);
    logic [5:0] trials [6];
    trials[0] = 6'h20; trials[1] = 6'h10; trials[2] = 6'h18;
    trials[3] = 6'h14; trials[4] = 6'h16; trials[5] = 6'h17;
    latency = -1;
    start = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      step();
      if (n == 1) start = 1'b0;
      if (mode == 3) begin
        for (int i = 0; i < 6; i++)
          if (n == 21 + 33 * i) chk($sformatf("trial%0d", i), trim_code, trials[i]);
      end
      if (mode == 5) begin
        if (n == 68) trim_ovr_en = 1'b1;
        if (n == 69) begin
          chk("ovr_mid", trim_code, 6'h05);
          trim_ovr_en = 1'b0;
        end
      end
      if (mode == 6) begin
        if (n == 10 || n == 150) start = 1'b1;
        if (n == 11 || n == 151) start = 1'b0;
        if (n == 100) chk("busy_after_restart", busy, 1'b1);
      end
      if (done === 1'b1) begin
        latency = n;
        break;
      end
    end
    if (latency < 0) begin
      total++;
      bad++;
      $error("FAIL timeout observed=none expected=done");
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    ena          = 1'b1;
    start        = 1'b0;
    trim_ovr_en  = 1'b0;
    trim_ovr_val = 6'h05;

    // 1: reset state
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("rst_trim", trim_code, 6'h20);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fail", fail, 1'b0);
    chk("rst_short", cal_short, 1'b0);

    // start ignored while disabled
    ena = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("start_no_ena_busy", busy, 1'b0);
    ena = 1'b1;
    step();

    // 2: comparator stuck low -> saturated all-ones
    cmp_val = 1'b0;
    run_cal(0, lat);
    chk("lat_c2", lat, 200);
    chk("short_during_c2_done", cal_short, 1'b0);
    repeat (2) step();
    chk("trim_c2", trim_code, 6'h3F);
    chk("fail_c2", fail, 1'b1);
    chk("busy_c2", busy, 1'b0);

    // 3: OTA model converges to 0x17
    ota_mode = 1'b1;
    step();
    run_cal(3, lat);
    chk("lat_c3", lat, 200);
    repeat (2) step();
    chk("trim_c3", trim_code, 6'h17);
    chk("fail_c3", fail, 1'b0);
    chk("done_c3", done, 1'b1);

    // 4: ena dropped during the 4th settle phase
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    for (int n = 1; n <= 105; n++) begin
      step();
      if (n == 1) start = 1'b0;
      if (n == 50) chk("busy_mid_c4", busy, 1'b1);
      if (n == 60) chk("short_mid_c4", cal_short, 1'b1);
    end
    ena = 1'b0;
    step();
    chk("abort_busy", busy, 1'b0);
    chk("abort_short", cal_short, 1'b0);
    chk("abort_done", done, 1'b0);
    step();
    chk("abort_trim", trim_code, 6'h20);
    ena = 1'b1;
    repeat (3) step();

    // 5: override pulse mid-calibration does not disturb the result
    run_cal(5, lat);
    chk("lat_c5", lat, 200);
    repeat (2) step();
    chk("trim_c5", trim_code, 6'h17);
    trim_ovr_en = 1'b1;
    step();
    chk("ovr_idle", trim_code, 6'h05);
    trim_ovr_en = 1'b0;
    step();
    chk("ovr_release", trim_code, 6'h17);

    // 6: exact ties keep every bit; extra starts while busy are ignored
    ota_mode = 1'b0;
    alt_mode = 1'b1;
    step();
    run_cal(6, lat);
    chk("lat_c6", lat, 200);
    repeat (2) step();
    chk("trim_c6", trim_code, 6'h3F);
    chk("fail_c6", fail, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
